// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the JTDSP16 do-loop cache: state encoding and do_data field layout.
package jtdsp16_pkg;

    localparam int unsigned DEF_DEPTH = 15;
    localparam int unsigned DEF_KW    = 4;
    localparam int unsigned DEF_NW    = 7;
    localparam int unsigned WORD_W    = 16;

    // do_data = {K, N}: N sits at the bottom, K directly above it
    localparam int unsigned N_LSB = 0;

    function automatic int unsigned k_lsb(input int unsigned nw);
        return nw;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_REPLAY = 2'd2
    } do_state_e;

endpackage

// File: rtl/jtdsp16_cache_mem.sv
// DEPTH x 16 register file: one synchronous write port gated by cen, one asynchronous read port.
module jtdsp16_cache_mem #(
    parameter int unsigned DEPTH = 15,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data_c
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cen && we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/jtdsp16_do_cache.sv
// Do-loop instruction cache and sequencer: captures K words after "do K,N", replays them N-1 times.
// Optional feature macro: JTDSP16_REDO_EN enables "redo N" (K==0) replay of the last stored block.
module jtdsp16_do_cache
    import jtdsp16_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned KW    = DEF_KW,
    parameter int unsigned NW    = DEF_NW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             do_start,
    input  logic [KW+NW-1:0] do_data,
    input  logic             fetch,
    input  logic [15:0]      rom_dout,
    output logic [15:0]      cache_dout,
    output logic             up_xcache,
    output logic             pc_hold,
    output logic             no_int,
    output logic [NW-1:0]    cloop,
    output logic             busy,
    output logic             err
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned K_LSB = k_lsb(NW);

`ifdef JTDSP16_REDO_EN
    localparam bit REDO_EN = 1'b1;
`else
    localparam bit REDO_EN = 1'b0;
`endif

    do_state_e       state, state_nx;
    logic [KW-1:0]   k_r, k_nx;
    logic [NW-1:0]   n_r, n_nx;
    logic [KW-1:0]   wr_ptr, wr_ptr_nx;
    logic [KW-1:0]   rd_ptr, rd_ptr_nx;
    logic [NW-1:0]   cloop_nx;
    logic            valid, valid_nx;
    logic            err_nx;
    logic            we_c;
    logic [KW-1:0]   req_k_c;
    logic [NW-1:0]   req_n_c;
    logic [15:0]     rd_data_c;

    assign req_k_c = do_data[K_LSB +: KW];
    assign req_n_c = do_data[N_LSB +: NW];

    jtdsp16_cache_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .cen       (cen),
        .we        (we_c),
        .wr_addr   (AW'(wr_ptr)),
        .wr_data   (rom_dout),
        .rd_addr   (AW'(rd_ptr)),
        .rd_data_c (rd_data_c)
    );

    // The cache only drives the instruction bus while replaying
    assign cache_dout = up_xcache ? rd_data_c : 16'd0;

    // State register plus registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            k_r       <= '0;
            n_r       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cloop     <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            no_int    <= 1'b0;
            up_xcache <= 1'b0;
            pc_hold   <= 1'b0;
        end else begin
            state     <= state_nx;
            k_r       <= k_nx;
            n_r       <= n_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            cloop     <= cloop_nx;
            valid     <= valid_nx;
            err       <= err_nx;
            busy      <= (state_nx != ST_IDLE);
            no_int    <= (state_nx != ST_IDLE);
            up_xcache <= (state_nx == ST_REPLAY);
            pc_hold   <= (state_nx == ST_REPLAY);
        end
    end

    // Next-state, pointer, loop-count and error logic
    always_comb begin
        state_nx  = state;
        k_nx      = k_r;
        n_nx      = n_r;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        cloop_nx  = cloop;
        valid_nx  = valid;
        err_nx    = 1'b0;
        we_c      = 1'b0;

        if (cen) begin
            // Requests are only honoured from IDLE; nested do is rejected
            if (do_start) begin
                if (state != ST_IDLE) begin
                    err_nx = 1'b1;
                end else if (req_n_c == '0) begin
                    err_nx = 1'b1;
                end else if (req_k_c == '0) begin
                    if (REDO_EN && valid) begin
                        state_nx  = ST_REPLAY;
                        n_nx      = req_n_c;
                        rd_ptr_nx = '0;
                        cloop_nx  = req_n_c;
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (32'(req_k_c) > DEPTH) begin
                    err_nx = 1'b1;
                end else begin
                    state_nx  = ST_FILL;
                    k_nx      = req_k_c;
                    n_nx      = req_n_c;
                    wr_ptr_nx = '0;
                    cloop_nx  = req_n_c;
                end
            end

            if (fetch) begin
                case (state)
                    ST_FILL: begin
                        we_c      = 1'b1;
                        wr_ptr_nx = wr_ptr + KW'(1);
                        if (wr_ptr == k_r - KW'(1)) begin
                            valid_nx  = 1'b1;
                            rd_ptr_nx = '0;
                            if (n_r == NW'(1)) begin
                                state_nx = ST_IDLE;
                                cloop_nx = '0;
                            end else begin
                                state_nx = ST_REPLAY;
                                cloop_nx = n_r - NW'(1);
                            end
                        end
                    end
                    ST_REPLAY: begin
                        if (rd_ptr == k_r - KW'(1)) begin
                            rd_ptr_nx = '0;
                            if (cloop == NW'(1)) begin
                                state_nx = ST_IDLE;
                                cloop_nx = '0;
                            end else begin
                                cloop_nx = cloop - NW'(1);
                            end
                        end else begin
                            rd_ptr_nx = rd_ptr + KW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtdsp16_do_cache.sv
// Self-checking bench for jtdsp16_do_cache with a loop-level reference model.
// Honours JTDSP16_REDO_EN the same way the design does.
module tb_jtdsp16_do_cache;

    // DEPTH below 2**KW-1 so that K > DEPTH is encodable
    localparam int unsigned DEPTH = 13;
    localparam int unsigned KW    = 4;
    localparam int unsigned NW    = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             cen;
    logic             do_start;
    logic [KW+NW-1:0] do_data;
    logic             fetch;
    logic [15:0]      rom_dout;
    logic [15:0]      cache_dout;
    logic             up_xcache;
    logic             pc_hold;
    logic             no_int;
    logic [NW-1:0]    cloop;
    logic             busy;
    logic             err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: last stored block and whether it is valid
    logic [15:0] mdl_blk[$];
    int          mdl_k     = 0;
    bit          mdl_valid = 1'b0;

    jtdsp16_do_cache #(
        .DEPTH (DEPTH),
        .KW    (KW),
        .NW    (NW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .do_start   (do_start),
        .do_data    (do_data),
        .fetch      (fetch),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .up_xcache  (up_xcache),
        .pc_hold    (pc_hold),
        .no_int     (no_int),
        .cloop      (cloop),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input bit c);
        cen = c;
        @(posedge clk);
        #1;
    endtask

    // One complete do (k>0) or redo (k==0) sequence, checked cycle by cycle.
    // inj_fill/inj_rep: fetch index at which an extra do_start is issued (-1 = none).
    // rst_rep: replay fetch index at which reset is asserted (-1 = none).
    task automatic run_do(input int k, input int n, input bit half, input bit gaps,
                          input int inj_fill, input int inj_rep, input int rst_rep);
        logic [15:0] w;
        bit redo;
        bit last;
        int reps;
        int total;
        int exp_cloop;
        redo = (k == 0);

        do_start = 1'b1;
        do_data  = {KW'(k), NW'(n)};
        fetch    = 1'b0;
        tick(1'b1);
        do_start = 1'b0;
        n_tests++;
        if (busy !== 1'b1 || err !== 1'b0 || cloop !== NW'(n) || up_xcache !== redo || pc_hold !== redo) begin
            n_fail++;
            $display("FAIL issue k=%0d n=%0d: busy=%b err=%b cloop=%0d up=%b hold=%b, want busy=1 err=0 cloop=%0d up=%b hold=%b",
                     k, n, busy, err, cloop, up_xcache, pc_hold, n, redo, redo);
        end

        if (!redo) begin
            mdl_blk.delete();
            for (int i = 0; i < k; i++) begin
                w = 16'($urandom);
                mdl_blk.push_back(w);
                if (gaps && $urandom_range(2) == 0) begin
                    fetch    = 1'b0;
                    rom_dout = ~w;
                    tick(1'b1);
                end
                if (half) begin
                    fetch    = 1'b1;
                    rom_dout = ~w;
                    tick(1'b0);
                end
                fetch    = 1'b1;
                rom_dout = w;
                if (i == inj_fill) begin
                    do_start = 1'b1;
                    do_data  = {KW'(1), NW'(1)};
                end
                tick(1'b1);
                do_start  = 1'b0;
                fetch     = 1'b0;
                last      = (i == k - 1);
                exp_cloop = !last ? n : (n > 1 ? n - 1 : 0);
                n_tests++;
                if (busy !== (!last || n > 1) || up_xcache !== (last && n > 1) ||
                    pc_hold !== (last && n > 1) || cloop !== NW'(exp_cloop) || err !== (i == inj_fill)) begin
                    n_fail++;
                    $display("FAIL fill k=%0d n=%0d i=%0d: busy=%b up=%b hold=%b cloop=%0d err=%b, want cloop=%0d err=%b",
                             k, n, i, busy, up_xcache, pc_hold, cloop, err, exp_cloop, i == inj_fill);
                end
            end
            mdl_k     = k;
            mdl_valid = 1'b1;
        end

        reps  = redo ? n : n - 1;
        total = reps * mdl_k;
        for (int j = 0; j < total; j++) begin
            if (half) begin
                fetch = 1'b1;
                tick(1'b0);
            end
            if (gaps && $urandom_range(3) == 0) begin
                fetch = 1'b0;
                tick(1'b1);
            end
            exp_cloop = reps - j / mdl_k;
            n_tests++;
            if (cache_dout !== mdl_blk[j % mdl_k] || cloop !== NW'(exp_cloop) || up_xcache !== 1'b1 ||
                pc_hold !== 1'b1 || busy !== 1'b1 || no_int !== 1'b1) begin
                n_fail++;
                $display("FAIL replay k=%0d n=%0d j=%0d: dout=%h cloop=%0d up=%b hold=%b busy=%b noint=%b, want dout=%h cloop=%0d",
                         mdl_k, n, j, cache_dout, cloop, up_xcache, pc_hold, busy, no_int, mdl_blk[j % mdl_k], exp_cloop);
            end
            fetch = 1'b1;
            if (j == rst_rep) rst = 1'b1;
            if (j == inj_rep) begin
                do_start = 1'b1;
                do_data  = {KW'(2), NW'(3)};
            end
            tick(1'b1);
            rst      = 1'b0;
            do_start = 1'b0;
            fetch    = 1'b0;
            if (j == rst_rep) begin
                n_tests++;
                if (busy !== 1'b0 || up_xcache !== 1'b0 || pc_hold !== 1'b0 || no_int !== 1'b0 ||
                    cloop !== '0 || err !== 1'b0 || cache_dout !== 16'd0) begin
                    n_fail++;
                    $display("FAIL reset_mid: busy=%b up=%b hold=%b noint=%b cloop=%0d err=%b dout=%h, want all 0",
                             busy, up_xcache, pc_hold, no_int, cloop, err, cache_dout);
                end
                mdl_valid = 1'b0;
                return;
            end
            n_tests++;
            if (err !== (j == inj_rep)) begin
                n_fail++;
                $display("FAIL replay_err j=%0d: err=%b want %b", j, err, j == inj_rep);
            end
        end

        n_tests++;
        if (busy !== 1'b0 || up_xcache !== 1'b0 || pc_hold !== 1'b0 || no_int !== 1'b0 ||
            cloop !== '0 || cache_dout !== 16'd0) begin
            n_fail++;
            $display("FAIL end k=%0d n=%0d: busy=%b up=%b hold=%b noint=%b cloop=%0d dout=%h, want all 0",
                     k, n, busy, up_xcache, pc_hold, no_int, cloop, cache_dout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick(1'b1);
        rst = 1'b0;
        tick(1'b1);
        mdl_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || up_xcache !== 1'b0 || pc_hold !== 1'b0 || no_int !== 1'b0 ||
            cloop !== '0 || err !== 1'b0 || cache_dout !== 16'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b up=%b hold=%b noint=%b cloop=%0d err=%b dout=%h, want all 0",
                     busy, up_xcache, pc_hold, no_int, cloop, err, cache_dout);
        end
    endtask

    // Illegal requests from IDLE; K==0 is illegal here because no valid block exists yet
    task automatic test_errors();
        int ks[5];
        int ns[5];
        ks = '{14, 15, 5, 0, int'($urandom_range(15, DEPTH + 1))};
        ns = '{3, 1, 0, 3, int'($urandom_range(20, 1))};
        for (int t = 0; t < 5; t++) begin
            do_start = 1'b1;
            do_data  = {KW'(ks[t]), NW'(ns[t])};
            tick(1'b1);
            do_start = 1'b0;
            n_tests++;
            if (err !== 1'b1 || busy !== 1'b0 || cloop !== '0 || up_xcache !== 1'b0) begin
                n_fail++;
                $display("FAIL err_idle k=%0d n=%0d: err=%b busy=%b cloop=%0d up=%b, want err=1 busy=0 cloop=0 up=0",
                         ks[t], ns[t], err, busy, cloop, up_xcache);
            end
            fetch = 1'b1;
            tick(1'b1);
            fetch = 1'b0;
            n_tests++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pulse k=%0d: err=%b busy=%b, want 0 0", ks[t], err, busy);
            end
        end
    endtask

    task automatic test_basic_loop();
        run_do(3, 4, 1'b0, 1'b0, -1, -1, -1);
    endtask

    task automatic test_single_iter();
        run_do(2, 1, 1'b0, 1'b0, -1, -1, -1);
    endtask

    task automatic test_busy_do();
        run_do(2, 3, 1'b0, 1'b0, -1, 1, -1);
        run_do(2, 1, 1'b0, 1'b0, 1, -1, -1);
        run_do(4, 2, 1'b0, 1'b0, 3, -1, -1);
        run_do(3, 2, 1'b0, 1'b0, 0, 2, -1);
    endtask

    task automatic test_reset_mid();
        run_do(4, 5, 1'b0, 1'b0, -1, -1, 1);
        run_do(1, 2, 1'b0, 1'b0, -1, -1, -1);
    endtask

    task automatic test_redo();
        run_do(2, 2, 1'b0, 1'b0, -1, -1, -1);
`ifdef JTDSP16_REDO_EN
        run_do(0, 3, 1'b0, 1'b0, -1, -1, -1);
`else
        do_start = 1'b1;
        do_data  = {KW'(0), NW'(3)};
        tick(1'b1);
        do_start = 1'b0;
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || up_xcache !== 1'b0) begin
            n_fail++;
            $display("FAIL redo_disabled: err=%b busy=%b up=%b, want 1 0 0", err, busy, up_xcache);
        end
        tick(1'b1);
`endif
    endtask

    task automatic test_half_rate();
        run_do(3, 4, 1'b1, 1'b0, -1, -1, -1);
        run_do(DEPTH, 2, 1'b1, 1'b0, -1, -1, -1);
    endtask

    task automatic test_random();
        int k;
        for (int t = 0; t < 25; t++) begin
            k = int'($urandom_range(DEPTH, 1));
`ifdef JTDSP16_REDO_EN
            if (mdl_valid && $urandom_range(3) == 0) k = 0;
`endif
            run_do(k, int'($urandom_range(4, 1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                   ($urandom_range(4) == 0) ? int'($urandom_range(k > 0 ? k - 1 : 0)) : -1,
                   ($urandom_range(4) == 0) ? int'($urandom_range(5)) : -1, -1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        cen      = 1'b1;
        do_start = 1'b0;
        do_data  = '0;
        fetch    = 1'b0;
        rom_dout = 16'd0;
        test_reset();
        test_errors();
        test_basic_loop();
        test_single_iter();
        test_busy_do();
        test_reset_mid();
        test_redo();
        test_half_rate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
